interrupt_source_capture: RTL

//  Upstream front end of the interrupt controller. Synchronises raw peripheral IRQ lines.

---
 rtl/interrupt_source_capture_if.sv | 22 ++
 rtl/interrupt_source_capture.sv | 118 +++++++++++
 2 files changed

// File: rtl/interrupt_source_capture_if.sv
// APB-style register access bundle for the interrupt source capture block.
interface interrupt_source_capture_if #(
    parameter int unsigned NUM_INTR = 16,
    parameter int unsigned ADDR_W   = 3
);
    logic                penable;
    logic                pwrite;
    logic [ADDR_W-1:0]   paddr;
    logic [NUM_INTR-1:0] pwdata;
    logic                pready;
    logic [NUM_INTR-1:0] prdata;

    modport master (
        output penable, pwrite, paddr, pwdata,
        input  pready, prdata
    );

    modport slave (
        input  penable, pwrite, paddr, pwdata,
        output pready, prdata
    );
endinterface

// File: rtl/interrupt_source_capture.sv
// Front end of the interrupt controller: synchronises raw IRQ lines, captures level/edge
// requests into a pending register and drives the masked pending vector.
module interrupt_source_capture #(
    parameter int unsigned NUM_INTR    = 16,
    parameter int unsigned WIDTH       = $clog2(NUM_INTR),
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      pclk_i,
    input  logic                      prst_i,
    interrupt_source_capture_if.slave apb,
    input  logic [NUM_INTR-1:0]       irq_raw_i,
    input  logic                      intr_ack_i,
    input  logic [WIDTH-1:0]          intr_ack_id_i,
    output logic [NUM_INTR-1:0]       interrupt_active_o
);

    localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_MODE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_PEND = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_RAW  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_OVF  = ADDR_W'(4);

    logic [NUM_INTR-1:0] r_sync [SYNC_STAGES];
    logic [NUM_INTR-1:0] r_prev;
    logic [NUM_INTR-1:0] r_mask;
    logic [NUM_INTR-1:0] r_mode;
    logic [NUM_INTR-1:0] r_pend;
    logic [NUM_INTR-1:0] r_ovf;
    logic [NUM_INTR-1:0] r_active;
    logic [NUM_INTR-1:0] r_prdata;
    logic                r_pready;

    logic                w_wr;
    logic                w_rd;
    logic [NUM_INTR-1:0] w_sync;
    logic [NUM_INTR-1:0] w_rise;
    logic [NUM_INTR-1:0] w_ack_clr;
    logic [NUM_INTR-1:0] w_w1c_pend;
    logic [NUM_INTR-1:0] w_w1c_ovf;
    logic [NUM_INTR-1:0] w_mode_flip;
    logic [NUM_INTR-1:0] w_edge_clr;
    logic [NUM_INTR-1:0] w_pend_d;
    logic [NUM_INTR-1:0] w_ovf_d;
    logic [NUM_INTR-1:0] w_rd_data;

    assign w_wr   = apb.penable & apb.pwrite;
    assign w_rd   = apb.penable & ~apb.pwrite;
    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_prev;

    // Out-of-range ids shift the one-hot off the top and clear nothing.
    assign w_ack_clr   = intr_ack_i ? (NUM_INTR'(1) << intr_ack_id_i) : '0;
    assign w_w1c_pend  = (w_wr && apb.paddr == A_PEND) ? apb.pwdata : '0;
    assign w_w1c_ovf   = (w_wr && apb.paddr == A_OVF) ? apb.pwdata : '0;
    assign w_mode_flip = (w_wr && apb.paddr == A_MODE) ? (apb.pwdata ^ r_mode) : '0;
    assign w_edge_clr  = w_ack_clr | w_w1c_pend;

    // Edge lines: a new rise wins over a same-cycle clear; a rise on an already-pending
    // line that is not being cleared in that cycle is an overflow.
    always_comb begin
        w_pend_d = ((~r_mode & w_sync) | (r_mode & (w_rise | (r_pend & ~w_edge_clr))))
                   & ~w_mode_flip;
        w_ovf_d  = (r_ovf & ~w_w1c_ovf) | (r_mode & w_rise & r_pend & ~w_edge_clr);
    end

    always_comb begin
        w_rd_data = '0;
        case (apb.paddr)
            A_MASK:  w_rd_data = r_mask;
            A_MODE:  w_rd_data = r_mode;
            A_PEND:  w_rd_data = r_pend;
            A_RAW:   w_rd_data = w_sync;
            A_OVF:   w_rd_data = r_ovf;
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_prev   <= '0;
            r_mask   <= '0;
            r_mode   <= '0;
            r_pend   <= '0;
            r_ovf    <= '0;
            r_active <= '0;
            r_prdata <= '0;
            r_pready <= 1'b0;
        end else begin
            r_sync[0] <= irq_raw_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev   <= w_sync;
            r_pend   <= w_pend_d;
            r_ovf    <= w_ovf_d;
            r_active <= r_pend & r_mask;
            r_pready <= apb.penable;
            if (w_wr && apb.paddr == A_MASK) begin
                r_mask <= apb.pwdata;
            end
            if (w_wr && apb.paddr == A_MODE) begin
                r_mode <= apb.pwdata;
            end
            if (w_rd) begin
                r_prdata <= w_rd_data;
            end
        end
    end

    assign apb.pready         = r_pready;
    assign apb.prdata         = r_prdata;
    assign interrupt_active_o = r_active;

endmodule
